// File: rtl/apb2mem_bridge.sv
// APB4 slave to single-cycle regf mem request bridge.
// Optional error counter enabled by defining APB2MEM_ERRCNT_EN.
module apb2mem_bridge #(
    parameter int PADDRWIDTH   = 15,
    parameter int MEMADDRWIDTH = 13,
    parameter int DATAWIDTH    = 32
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_i,
    input  logic                    apb_psel_i,
    input  logic                    apb_penable_i,
    input  logic                    apb_pwrite_i,
    input  logic [PADDRWIDTH-1:0]   apb_paddr_i,
    input  logic [DATAWIDTH-1:0]    apb_pwdata_i,
    input  logic [3:0]              apb_pstrb_i,
    output logic [DATAWIDTH-1:0]    apb_prdata_o,
    output logic                    apb_pready_o,
    output logic                    apb_pslverr_o,
`ifdef APB2MEM_ERRCNT_EN
    input  logic                    err_cnt_clr_i,
    output logic [7:0]              err_cnt_o,
`endif
    output logic                    mem_ena_o,
    output logic [MEMADDRWIDTH-1:0] mem_addr_o,
    output logic                    mem_wena_o,
    output logic [DATAWIDTH-1:0]    mem_wdata_o,
    input  logic [DATAWIDTH-1:0]    mem_rdata_i,
    input  logic                    mem_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    ena_nxt;
    logic                    wena_nxt;
    logic [MEMADDRWIDTH-1:0] addr_nxt;
    logic [DATAWIDTH-1:0]    wdata_nxt;
    logic [DATAWIDTH-1:0]    prdata_nxt;
    logic                    pready_nxt;
    logic                    pslverr_nxt;
    logic                    setup;
    logic                    reject;

    assign setup  = apb_psel_i && !apb_penable_i;
    assign reject = (apb_paddr_i[1:0] != 2'b00) ||
                    (apb_pwrite_i && (apb_pstrb_i != 4'hF));

    // Next state and next registered output values.
    always_comb begin
        state_nxt   = state;
        ena_nxt     = 1'b0;
        wena_nxt    = 1'b0;
        addr_nxt    = mem_addr_o;
        wdata_nxt   = '0;
        prdata_nxt  = '0;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (reject) begin
                        state_nxt   = RESP;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                    end else begin
                        state_nxt = REQ;
                        ena_nxt   = 1'b1;
                        wena_nxt  = apb_pwrite_i;
                        addr_nxt  = apb_paddr_i[PADDRWIDTH-1:2];
                        if (apb_pwrite_i) begin
                            wdata_nxt = apb_pwdata_i;
                        end
                    end
                end
            end
            REQ: begin
                state_nxt   = RESP;
                pready_nxt  = 1'b1;
                pslverr_nxt = mem_err_i;
                if (!mem_wena_o) begin
                    prdata_nxt = mem_rdata_i;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending strobe.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state         <= IDLE;
            mem_ena_o     <= 1'b0;
            mem_wena_o    <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            apb_prdata_o  <= '0;
            apb_pready_o  <= 1'b0;
            apb_pslverr_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            mem_ena_o     <= ena_nxt;
            mem_wena_o    <= wena_nxt;
            mem_addr_o    <= addr_nxt;
            mem_wdata_o   <= wdata_nxt;
            apb_prdata_o  <= prdata_nxt;
            apb_pready_o  <= pready_nxt;
            apb_pslverr_o <= pslverr_nxt;
        end
    end

`ifdef APB2MEM_ERRCNT_EN
    // Saturating count of error completions; clear beats increment.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            err_cnt_o <= '0;
        end else if (err_cnt_clr_i) begin
            err_cnt_o <= '0;
        end else if ((state == RESP) && apb_pslverr_o &&
                     (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apb2mem_bridge.sv
// Self-checking bench for apb2mem_bridge.
// Cycle-indexed expectation schedule filled by transfer-level model.
`timescale 1ns/1ps
module tb_apb2mem_bridge;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [14:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        mem_ena;
    logic [12:0] mem_addr;
    logic        mem_wena;
    logic [31:0] mem_wdata;
    logic [31:0] regf_rdata;
    logic        regf_err;
`ifdef APB2MEM_ERRCNT_EN
    logic        cnt_clr;
    logic [7:0]  cnt;
`endif

    apb2mem_bridge dut (
        .main_clk_i    (clk),
        .main_rst_i    (rst),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pwrite_i  (pwrite),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
        .apb_pstrb_i   (pstrb),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
`ifdef APB2MEM_ERRCNT_EN
        .err_cnt_clr_i (cnt_clr),
        .err_cnt_o     (cnt),
`endif
        .mem_ena_o     (mem_ena),
        .mem_addr_o    (mem_addr),
        .mem_wena_o    (mem_wena),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (regf_rdata),
        .mem_err_i     (regf_err)
    );

    localparam int NCYC = 4096;

    logic        exp_ena   [NCYC];
    logic        exp_wena  [NCYC];
    logic [12:0] exp_addr  [NCYC];
    logic [31:0] exp_wdata [NCYC];
    logic        exp_rdy   [NCYC];
    logic        exp_err   [NCYC];
    logic [31:0] exp_rdata [NCYC];

    int          cyc;
    int          n_chk;
    int          n_fail;
    bit          chk_on;
    logic [31:0] last_prdata;
    logic        last_err;
    int          ena_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of all outputs against the schedule.
    always @(negedge clk) begin
        if (chk_on && cyc < NCYC) begin
            chk("mem_ena", {31'd0, mem_ena}, {31'd0, exp_ena[cyc]});
            if (exp_ena[cyc]) begin
                chk("mem_addr", {19'd0, mem_addr}, {19'd0, exp_addr[cyc]});
                chk("mem_wena", {31'd0, mem_wena}, {31'd0, exp_wena[cyc]});
                chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
            end else begin
                chk("mem_wena_idle", {31'd0, mem_wena}, 32'd0);
                chk("mem_wdata_idle", mem_wdata, 32'd0);
            end
            chk("pready", {31'd0, pready}, {31'd0, exp_rdy[cyc]});
            chk("pslverr", {31'd0, pslverr}, {31'd0, exp_err[cyc]});
            chk("prdata", prdata, exp_rdata[cyc]);
        end
    end

    // Record completions and strobes for the literal checks.
    always @(negedge clk) begin
        if (chk_on) begin
            if (pready) begin
                last_prdata = prdata;
                last_err    = pslverr;
            end
            if (mem_ena) ena_q.push_back(cyc);
        end
    end

    task automatic xfer(input logic wr, input logic [14:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] rv, input logic ev,
                        input bit drop);
        int k;
        int n;
        bit rej;
        k   = cyc;
        rej = (a[1:0] != 2'b00) || (wr && st != 4'hF);
        regf_rdata = rv;
        regf_err   = ev;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        if (rej) begin
            exp_rdy[k+1]   = 1'b1;
            exp_err[k+1]   = 1'b1;
            exp_rdata[k+1] = 32'd0;
        end else begin
            exp_ena[k+1]   = 1'b1;
            exp_wena[k+1]  = wr;
            exp_addr[k+1]  = a[14:2];
            exp_wdata[k+1] = wr ? wd : 32'd0;
            exp_rdy[k+2]   = 1'b1;
            exp_err[k+2]   = ev;
            exp_rdata[k+2] = wr ? 32'd0 : rv;
        end
        @(posedge clk);
        #1;
        if (drop) begin
            psel    = 1'b0;
            penable = 1'b0;
        end else begin
            penable = 1'b1;
        end
        n = 0;
        while (!pready && n < 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pready_seen", {31'd0, pready}, 32'd1);
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int k0;
    int g;

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_ena[i]   = 1'b0;
            exp_wena[i]  = 1'b0;
            exp_addr[i]  = '0;
            exp_wdata[i] = '0;
            exp_rdy[i]   = 1'b0;
            exp_err[i]   = 1'b0;
            exp_rdata[i] = '0;
        end
        cyc        = 0;
        n_chk      = 0;
        n_fail     = 0;
        chk_on     = 1'b0;
        rst        = 1'b1;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = '0;
        pwdata     = '0;
        pstrb      = '0;
        regf_rdata = '0;
        regf_err   = 1'b0;
`ifdef APB2MEM_ERRCNT_EN
        cnt_clr    = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_mem_ena", {31'd0, mem_ena}, 32'd0);
        chk("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
`ifdef APB2MEM_ERRCNT_EN
        chk("rst_err_cnt", {24'd0, cnt}, 32'd0);
`endif
        idle(2);
        rst = 1'b0;
        idle(1);

        xfer(1'b1, 15'h0000, 32'h2, 4'hF, 32'h0, 1'b0, 1'b0);
        chk("wr0_ok", {31'd0, last_err}, 32'd0);
        idle(1);

        xfer(1'b0, 15'h0000, 32'hDEAD, 4'h0, 32'h10, 1'b0, 1'b0);
        chk("rd0_data", last_prdata, 32'h10);
        idle(2);

        xfer(1'b0, 15'h0004, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        chk("rd4_err", {31'd0, last_err}, 32'd1);
        chk("rd4_data", last_prdata, 32'h0);
        idle(1);

`ifdef APB2MEM_ERRCNT_EN
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        chk("cnt_clr0", {24'd0, cnt}, 32'd0);
`endif
        g = ena_q.size();
        xfer(1'b0, 15'h0002, 32'h0, 4'h0, 32'h55, 1'b0, 1'b0);
        xfer(1'b1, 15'h0008, 32'h77, 4'h3, 32'h0, 1'b0, 1'b0);
        chk("reject_no_ena", ena_q.size(), g);
        chk("reject_err", {31'd0, last_err}, 32'd1);
`ifdef APB2MEM_ERRCNT_EN
        chk("cnt_two", {24'd0, cnt}, 32'd2);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        chk("cnt_clr1", {24'd0, cnt}, 32'd0);
`endif
        idle(1);

        xfer(1'b1, 15'h0000, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 15'h0004, 32'h5A5A_0002, 4'hF, 32'h0, 1'b0, 1'b0);
        chk("b2b_gap", ena_q[$] - ena_q[$-1], 32'd3);
        idle(2);

        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 15'h0010;
        idle(2);
        psel    = 1'b0;
        penable = 1'b0;
        idle(1);

        xfer(1'b0, 15'h7FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        chk("drop_data", last_prdata, 32'hCAFE_F00D);
        idle(1);

        k0 = cyc;
        regf_rdata = 32'h1234;
        regf_err   = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 15'h0008;
        exp_ena[k0+1]  = 1'b1;
        exp_wena[k0+1] = 1'b0;
        exp_addr[k0+1] = 13'h2;
        idle(1);
        penable = 1'b1;
        rst     = 1'b1;
        idle(1);
        rst     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        chk("midrst_ena", {31'd0, mem_ena}, 32'd0);
        chk("midrst_pready", {31'd0, pready}, 32'd0);
        chk("midrst_addr", {19'd0, mem_addr}, 32'd0);
        idle(1);

        xfer(1'b0, 15'h000C, 32'h0, 4'h0, 32'h0000_ABCD, 1'b0, 1'b0);
        chk("post_rst_data", last_prdata, 32'h0000_ABCD);
        idle(3);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb2mem_bridge.md
Name: apb2mem_bridge

Overview:
- Upstream stage for the generated register files: converts an APB4 slave access into the single-cycle mem request interface the regf consumes (ena/addr/wena/wdata in, rdata/err back).
- The FSM issues exactly one registered mem strobe per APB transfer.
- It captures the regf's combinational response and returns it as an APB completion.
- Misaligned accesses and partial-strobe writes are rejected locally, without any mem access.

Parameters:
- PADDRWIDTH, 15, APB byte-address width.
- MEMADDRWIDTH, 13, word-address width toward regf; must equal PADDRWIDTH-2.
- DATAWIDTH, 32, data width; fixed at 32 (pstrb is 4 bits).

Ports:
- main_clk_i  in  1  clock
- main_rst_i  in  1  synchronous reset, active-high
- apb_psel_i  in  1  APB select
- apb_penable_i  in  1  APB access phase
- apb_pwrite_i  in  1  1=write
- apb_paddr_i  in  PADDRWIDTH  byte address
- apb_pwdata_i  in  32  write data
- apb_pstrb_i  in  4  write byte strobes
- apb_prdata_o  out  32  read data
- apb_pready_o  out  1  transfer complete
- apb_pslverr_o  out  1  transfer error
- mem_ena_o  out  1  regf access strobe
- mem_addr_o  out  MEMADDRWIDTH  word address = paddr[PADDRWIDTH-1:2]
- mem_wena_o  out  1  1=write
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  regf read data, valid in the mem_ena_o cycle
- mem_err_i  in  1  regf decode error, valid in the mem_ena_o cycle

Behaviour:
- One clock: main_clk_i. Reset main_rst_i is synchronous and active-high.
- All outputs are registered. Reset values:
  - state IDLE
  - mem_ena_o=0, mem_wena_o=0, mem_addr_o=0, mem_wdata_o=0
  - apb_pready_o=0, apb_pslverr_o=0, apb_prdata_o=0
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On psel=1 & penable=0 (setup phase), capture pwrite, paddr, pwdata, pstrb.
  - Reject when paddr[1:0]!=0, or when a write has pstrb!=4'hF: next state RESP with err=1, rdata=0, no mem access.
  - Otherwise next state REQ; mem_ena_o=1, mem_wena_o=pwrite, mem_addr_o=paddr[PADDRWIDTH-1:2], mem_wdata_o=pwdata (0 for reads).
- REQ (exactly one cycle, mem_ena_o=1):
  - Latch rdata = mem_wena_o ? 0 : mem_rdata_i.
  - Latch err = mem_err_i.
  - Next state RESP. mem_ena_o=0, mem_wena_o=0, mem_wdata_o=0 from the next cycle.
- RESP (one cycle):
  - apb_pready_o=1, apb_prdata_o=latched rdata, apb_pslverr_o=latched err.
  - Next state IDLE. pready/pslverr/prdata return to 0 in the following cycle.
- Latency:
  - Legal transfer: setup T0, access T1 (mem strobe), pready in T2. Total 3 cycles, one wait state.
  - Rejected transfer: pready in T1, no wait state.
- Back-to-back: the setup of the next transfer, in the cycle after RESP, is accepted in IDLE with no bubble.
- psel dropped during REQ/RESP (protocol violation): the transfer still completes and returns to IDLE. The mem access is never retracted.
- psel=1 & penable=1 seen in IDLE (missed setup): ignored, no capture.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. A pending REQ strobe is dropped.
- Exactly one mem_ena_o pulse per legal transfer; never two consecutive mem_ena_o cycles.

Optional Feature:
- Macro: APB2MEM_ERRCNT_EN.
- With the macro defined, the block adds these ports:
  - err_cnt_clr_i  in  1
  - err_cnt_o  out  8
- Counter behaviour:
  - Increments on every RESP cycle with apb_pslverr_o=1, saturating at 8'hFF.
  - Synchronous clear via err_cnt_clr_i; clear wins over a simultaneous increment.
  - Reset value 0.
- Without the macro: no counter logic and no such ports.

Test Plan:
- Write paddr=0x0000, pwdata=0x2, pstrb=F -> T1: mem_ena_o=1, wena=1, addr=0, wdata=0x2. T2: pready=1, pslverr=0.
- Read paddr=0x0000 with regf returning 0x10 -> T1: mem_ena_o=1, wena=0. T2: prdata=0x10, pready=1.
- Read paddr=0x0004 with regf mem_err_i=1 -> T2: pslverr=1, prdata=0.
- Misaligned paddr=0x0002 read, then write pstrb=4'h3 -> each completes in T1 with pslverr=1 and no mem_ena_o pulse. With APB2MEM_ERRCNT_EN: err_cnt_o=2, then err_cnt_clr_i -> 0.
- Two back-to-back writes to 0x0 and 0x4 -> mem_ena_o pulses exactly 3 cycles apart, each pready 1 cycle wide, no idle gap.
- main_rst_i asserted in REQ cycle -> next cycle: state IDLE, mem_ena_o=0, pready=0. A subsequent read completes normally.
